vram_port_arbiter: RTL and testbench
====================================

Name: vram_port_arbiter

Overview:
- Shares one simple dual-port frame RAM (one write port, one read port, registered read, 1-cycle latency) between two writers and two readers.
- Typical use: writer 0 = pixel input path, writer 1 = CPU/overlay; reader 0 = display scanout, reader 1 = processing engine.
- Round-robin arbitration on each port, read-response routing by tag, and a stale-read flag.
- Sits between the requesters and the RAM instance; the RAM itself stays external.

Parameters:
- DATA_WIDTH, 15, pixel/word width (RGB555).
- ADDR_WIDTH, 16, RAM address bits; depth = 2**ADDR_WIDTH.

Ports:
- clk  in  1  single system clock; everything rising-edge.
- reset  in  1  synchronous, active-high reset.
- wrN_req  in  1  writer N (N=0,1) requests a write.
- wrN_addr  in  ADDR_WIDTH  writer N address; must be held stable while wrN_req=1 and wrN_gnt=0.
- wrN_data  in  DATA_WIDTH  writer N data; must be held stable with its address.
- wrN_gnt  out  1  write of writer N happens this cycle.
- rdN_req  in  1  reader N (N=0,1) requests a read.
- rdN_addr  in  ADDR_WIDTH  reader N address; held stable until granted.
- rdN_gnt  out  1  read of reader N is issued this cycle.
- rdN_valid  out  1  rdN_data carries the response to reader N's previous grant.
- rdN_data  out  DATA_WIDTH  read data for reader N.
- rd_stale  out  1  the response delivered this cycle was read at the same address as a write in the issue cycle, so it holds the pre-write data.
- ram_we  out  1  RAM write enable.
- ram_write_addr  out  ADDR_WIDTH  RAM write address.
- ram_data  out  DATA_WIDTH  RAM write data.
- ram_read_addr  out  ADDR_WIDTH  RAM read address.
- ram_q  in  DATA_WIDTH  RAM registered read data; valid one cycle after ram_read_addr is presented.

Behaviour:
- Transfer rule: a transfer occurs in any cycle where req=1 and gnt=1.
  - Grants are combinational from the current req and the round-robin pointer.
  - At most one write grant and one read grant per cycle.
  - Read and write arbitration are independent; one read and one write may be granted in the same cycle.
- Round-robin, per port (write pointer wr_ptr, read pointer rd_ptr, 1 bit each):
  - Only one requester: it is granted and the pointer is unchanged.
  - Both requesting: the requester indicated by the pointer wins, and the pointer flips to the other at the clock edge.
  - Neither requesting: no grant, pointer unchanged.
- Write mux:
  - ram_we = wr0_gnt | wr1_gnt.
  - ram_write_addr and ram_data come from the granted writer; writer 0's values when idle.
  - No write-side latency.
- Read mux and response:
  - ram_read_addr comes from the granted reader; reader 0's address when idle.
  - A registered tag stage (valid bit + requester id) captures each read grant.
  - In the next cycle, rdN_valid=1 only for the tagged requester.
  - rdN_data = ram_q, passed through combinationally to both readers; meaningful only while rdN_valid=1.
  - Read latency is exactly 1 cycle from grant.
  - Back-to-back reads are supported: one response per cycle, responses in grant order.
- Same-address collision:
  - If a read grant and a write grant in the same cycle use the same address, the RAM returns the old data; no bypass is added.
  - A registered compare sets rd_stale=1 in the response cycle. rd_stale is 0 whenever no rdN_valid is asserted.
- Reset:
  - While reset=1, all gnt outputs, ram_we, rdN_valid and rd_stale are 0.
  - wr_ptr and rd_ptr clear to 0 (requester 0 favoured first).
  - Tag valid and the stale register clear to 0.
  - A read granted in the cycle before reset asserts produces no rdN_valid; its response is dropped.
  - Requests are honoured from the first cycle after reset deasserts.
- Address wrap: none inside the block. Addresses pass through unmodified over the full 0 .. 2**ADDR_WIDTH-1 range.

Decomposition:
- Shared package: requester-id constants (REQ0=0, REQ1=1) and the DATA_WIDTH/ADDR_WIDTH defaults used by the RAM and the video blocks.
- One sub-module: rr_arbiter2.
  - Contains the 2-requester round-robin grant logic and its pointer register.
  - Instantiated twice, once for the write port and once for the read port.
- The read tag/stale pipeline stays in the top level.

Test Plan:
1. Reset, then wr0_req with addr 0x0010/data 0x7C00 alone -> wr0_gnt=1 and ram_we=1 with addr 0x0010/data 0x7C00 the same cycle; wr_ptr unchanged.
2. wr0_req and wr1_req held for 4 cycles (addrs 0x0001/0x0002) -> grants alternate wr0, wr1, wr0, wr1; ram_write_addr alternates 0x0001, 0x0002.
3. rd0_req and rd1_req held; RAM model preloaded with 0x1234 at addr 0x0100 (reader 0) and 0x0ABC at 0x0200 (reader 1) -> rd0_valid with 0x1234 one cycle after rd0_gnt; rd1_valid with 0x0ABC one cycle after rd1_gnt; never both valid in the same cycle.
4. Same cycle: wr1 writes 0x00FF to 0x0300 (old contents 0x0001) and rd0 reads 0x0300 -> next cycle rd0_data=0x0001 with rd_stale=1; a repeat read gives 0x00FF with rd_stale=0.
5. rd1 granted at cycle t, reset=1 at t+1 -> rd1_valid=0 at t+1; all grants 0 during reset; after release with both readers requesting, reader 0 is granted first.

Source files
------------

// File: rtl/vram_port_arbiter_pkg.sv
// Shared definitions for the frame-RAM port arbiter and the video blocks around it.
package vram_port_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 15;
    localparam int ADDR_WIDTH_DEF = 16;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Captured at read grant, consumed in the response cycle.
    typedef struct packed {
        logic vld;
        logic id;
        logic stale;
    } rd_tag_t;

endpackage

// File: rtl/vram_port_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; grants are combinational, pointer flips only on contention.
module rr_arbiter2
    import vram_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        if (!reset) begin
            if (req_i[REQ0] && req_i[REQ1]) begin
                gnt_o[ptr_q] = 1'b1;
                ptr_d        = ~ptr_q;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= REQ0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares one simple dual-port frame RAM between two writers and two readers, routing
// registered read data back by tag and flagging reads that raced a same-address write.
module vram_port_arbiter
    import vram_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr0_req,
    input  logic [ADDR_WIDTH-1:0] wr0_addr,
    input  logic [DATA_WIDTH-1:0] wr0_data,
    output logic                  wr0_gnt,
    input  logic                  wr1_req,
    input  logic [ADDR_WIDTH-1:0] wr1_addr,
    input  logic [DATA_WIDTH-1:0] wr1_data,
    output logic                  wr1_gnt,
    input  logic                  rd0_req,
    input  logic [ADDR_WIDTH-1:0] rd0_addr,
    output logic                  rd0_gnt,
    output logic                  rd0_valid,
    output logic [DATA_WIDTH-1:0] rd0_data,
    input  logic                  rd1_req,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    output logic                  rd1_gnt,
    output logic                  rd1_valid,
    output logic [DATA_WIDTH-1:0] rd1_data,
    output logic                  rd_stale,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    logic [1:0] wr_gnt, rd_gnt;
    rd_tag_t    tag_q, tag_d;
    logic       resp_ok;

    rr_arbiter2 u_wr_arb (
        .clk   (clk),
        .reset (reset),
        .req_i ({wr1_req, wr0_req}),
        .gnt_o (wr_gnt)
    );

    rr_arbiter2 u_rd_arb (
        .clk   (clk),
        .reset (reset),
        .req_i ({rd1_req, rd0_req}),
        .gnt_o (rd_gnt)
    );

    assign wr0_gnt = wr_gnt[REQ0];
    assign wr1_gnt = wr_gnt[REQ1];
    assign rd0_gnt = rd_gnt[REQ0];
    assign rd1_gnt = rd_gnt[REQ1];

    assign ram_we         = |wr_gnt;
    assign ram_write_addr = wr_gnt[REQ1] ? wr1_addr : wr0_addr;
    assign ram_data       = wr_gnt[REQ1] ? wr1_data : wr0_data;
    assign ram_read_addr  = rd_gnt[REQ1] ? rd1_addr : rd0_addr;

    // RAM has no write-through, so a same-address race returns the old word.
    always_comb begin
        tag_d.vld   = |rd_gnt;
        tag_d.id    = rd_gnt[REQ1];
        tag_d.stale = (|rd_gnt) && ram_we && (ram_read_addr == ram_write_addr);
    end

    always_ff @(posedge clk) begin
        if (reset) tag_q <= '0;
        else       tag_q <= tag_d;
    end

    // Gating with reset drops a response whose grant landed just before reset.
    assign resp_ok   = tag_q.vld && !reset;
    assign rd0_valid = resp_ok && (tag_q.id == REQ0);
    assign rd1_valid = resp_ok && (tag_q.id == REQ1);
    assign rd_stale  = resp_ok && tag_q.stale;
    assign rd0_data  = ram_q;
    assign rd1_data  = ram_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Scoreboard bench: a reference model predicts grants, muxing and read responses; a monitor
// pops predicted responses and compares them with what the arbiter delivers.
module tb_vram_port_arbiter;

    localparam int DW = 15;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr0_req, wr1_req, rd0_req, rd1_req;
    logic [AW-1:0] wr0_addr, wr1_addr, rd0_addr, rd1_addr;
    logic [DW-1:0] wr0_data, wr1_data;
    logic          wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt;
    logic          rd0_valid, rd1_valid, rd_stale, ram_we;
    logic [DW-1:0] rd0_data, rd1_data, ram_data, ram_q;
    logic [AW-1:0] ram_write_addr, ram_read_addr;

    vram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
        .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
        .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt),
        .rd0_valid(rd0_valid), .rd0_data(rd0_data),
        .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt),
        .rd1_valid(rd1_valid), .rd1_data(rd1_data),
        .rd_stale(rd_stale), .ram_we(ram_we), .ram_write_addr(ram_write_addr),
        .ram_data(ram_data), .ram_read_addr(ram_read_addr), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External RAM: registered read, old data on same-address write.
    logic [DW-1:0] ram_mem [0:65535];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_write_addr] <= ram_data;
        ram_q <= ram_mem[ram_read_addr];
    end

    // Reference state
    logic [DW-1:0] ref_mem [0:65535];
    int            m_wptr, m_rptr;
    typedef struct { int id; logic [DW-1:0] data; logic stale; int due; } exp_t;
    exp_t q[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Round-robin rule: lone requester wins; on contention the pointed-to one wins.
    function automatic int pick(input logic r0, input logic r1, input int ptr);
        if (r0 && r1) return ptr;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    always @(negedge clk) begin : model
        int   w, r;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;
        exp_t it;
        if (reset) begin
            chk("gnt_in_reset", {wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt, ram_we}, 0);
            m_wptr = 0;
            m_rptr = 0;
        end else begin
            w = pick(wr0_req, wr1_req, m_wptr);
            r = pick(rd0_req, rd1_req, m_rptr);
            if (wr0_req && wr1_req) m_wptr = 1 - m_wptr;
            if (rd0_req && rd1_req) m_rptr = 1 - m_rptr;
            wa = (w == 1) ? wr1_addr : wr0_addr;
            wd = (w == 1) ? wr1_data : wr0_data;
            ra = (r == 1) ? rd1_addr : rd0_addr;
            chk("grants", {wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt, ram_we},
                {w == 0, w == 1, r == 0, r == 1, w >= 0});
            chk("wr_mux", {ram_write_addr, ram_data}, {wa, wd});
            chk("rd_addr", ram_read_addr, ra);
            if (r >= 0) begin
                it.id    = r;
                it.data  = ref_mem[ra];
                it.stale = (w >= 0) && (wa == ra);
                it.due   = cyc + 1;
                q.push_back(it);
            end
            if (w >= 0) ref_mem[wa] = wd;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t it;
        if (reset) begin
            chk("resp_in_reset", {rd0_valid, rd1_valid, rd_stale}, 0);
            while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
        end else if (rd0_valid || rd1_valid) begin
            if (q.size() == 0 || q[0].due != cyc) begin
                chk("unexpected_resp", {rd0_valid, rd1_valid}, 0);
            end else begin
                it = q.pop_front();
                chk("resp_route", {rd0_valid, rd1_valid}, (it.id == 1) ? 2'b01 : 2'b10);
                chk("resp_data", {rd0_data, rd1_data}, {it.data, it.data});
                chk("resp_stale", rd_stale, it.stale);
            end
        end else begin
            chk("stale_idle", rd_stale, 0);
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("missing_resp", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    function automatic logic [AW-1:0] raddr();
        case ($urandom_range(0, 5))
            0: return 16'h0300;
            1: return 16'h0301;
            2: return 16'h0000;
            3: return 16'hFFFF;
            default: return AW'($urandom);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] sg;
        for (int a = 0; a < 65536; a++) begin
            ram_mem[a] = DW'(a) ^ 15'h2AAA;
            ref_mem[a] = DW'(a) ^ 15'h2AAA;
        end
        ram_mem[16'h0100] = 15'h1234; ref_mem[16'h0100] = 15'h1234;
        ram_mem[16'h0200] = 15'h0ABC; ref_mem[16'h0200] = 15'h0ABC;
        ram_mem[16'h0300] = 15'h0001; ref_mem[16'h0300] = 15'h0001;

        reset = 1'b1;
        {wr0_req, wr1_req, rd0_req, rd1_req} = '0;
        {wr0_addr, wr1_addr, rd0_addr, rd1_addr} = '0;
        {wr0_data, wr1_data} = '0;
        repeat (3) step();
        reset = 1'b0;

        // Lone writer 0
        wr0_req = 1'b1; wr0_addr = 16'h0010; wr0_data = 15'h7C00;
        @(negedge clk);
        chk("t1_write", {wr0_gnt, ram_we, ram_write_addr, ram_data}, {1'b1, 1'b1, 16'h0010, 15'h7C00});
        step();

        // Both writers contend: wr0, wr1, wr0, wr1
        wr1_req = 1'b1; wr0_addr = 16'h0001; wr1_addr = 16'h0002; wr1_data = 15'h001F;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_alternate", {wr0_gnt, wr1_gnt, ram_write_addr},
                (i % 2 == 0) ? {2'b10, 16'h0001} : {2'b01, 16'h0002});
            step();
        end
        wr0_req = 1'b0; wr1_req = 1'b0;

        // Both readers contend; data routing checked by the scoreboard
        rd0_req = 1'b1; rd0_addr = 16'h0100; rd1_req = 1'b1; rd1_addr = 16'h0200;
        repeat (4) step();
        rd0_req = 1'b0; rd1_req = 1'b0;
        step();

        // Same-address write/read race, then a clean re-read
        wr1_req = 1'b1; wr1_addr = 16'h0300; wr1_data = 15'h00FF;
        rd0_req = 1'b1; rd0_addr = 16'h0300;
        step();
        wr1_req = 1'b0; rd0_req = 1'b0;
        @(negedge clk);
        chk("t4_stale", {rd0_valid, rd0_data, rd_stale}, {1'b1, 15'h0001, 1'b1});
        rd0_req = 1'b1;
        step();
        rd0_req = 1'b0;
        @(negedge clk);
        chk("t4_fresh", {rd0_valid, rd0_data, rd_stale}, {1'b1, 15'h00FF, 1'b0});
        step();

        // Read granted just before reset is dropped; reader 0 first after release
        rd1_req = 1'b1; rd1_addr = 16'h0200;
        step();
        reset = 1'b1; rd0_req = 1'b1; rd0_addr = 16'h0100;
        @(negedge clk);
        chk("t5_dropped", {rd0_valid, rd1_valid, rd0_gnt, rd1_gnt}, 0);
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_first_after_reset", {rd0_gnt, rd1_gnt}, 2'b10);
        step();
        rd0_req = 1'b0; rd1_req = 1'b0;

        // Randomized traffic; requests hold until granted
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            sg = {wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt};
            step();
            reset = ($urandom_range(0, 199) == 0);
            if (wr0_req && sg[3]) wr0_req = 1'b0;
            if (!wr0_req && $urandom_range(0, 2) != 0) begin
                wr0_req = 1'b1; wr0_addr = raddr(); wr0_data = DW'($urandom);
            end
            if (wr1_req && sg[2]) wr1_req = 1'b0;
            if (!wr1_req && $urandom_range(0, 2) != 0) begin
                wr1_req = 1'b1; wr1_addr = raddr(); wr1_data = DW'($urandom);
            end
            if (rd0_req && sg[1]) rd0_req = 1'b0;
            if (!rd0_req && $urandom_range(0, 2) != 0) begin
                rd0_req = 1'b1; rd0_addr = raddr();
            end
            if (rd1_req && sg[0]) rd1_req = 1'b0;
            if (!rd1_req && $urandom_range(0, 2) != 0) begin
                rd1_req = 1'b1; rd1_addr = raddr();
            end
        end

        reset = 1'b0;
        {wr0_req, wr1_req, rd0_req, rd1_req} = '0;
        repeat (3) step();
        @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
